// File: rtl/mem_req_arbiter_pkg.sv
// Shared ids, size encodings and request bundle for the memory request arbiter.
// Pure declarations: no latency, no flow control.
package mem_req_arbiter_pkg;

  localparam logic ARB_ID_INST = 1'b0;
  localparam logic ARB_ID_DATA = 1'b1;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_cmd_t;

  function automatic logic other_id(input logic id);
    return ~id;
  endfunction

endpackage

// File: rtl/mem_req_arbiter_tag_fifo.sv
// In-order owner-tag FIFO; dout shows the head combinationally, push/pop take effect at the edge.
// Push while full and pop while empty are ignored; the caller is expected to gate them.
module arb_tag_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Two-master to one sram-like port arbiter with in-order response routing; optional ARB_RR_EN round-robin.
// Zero-cycle request/response paths; mem_req drops while the tag FIFO is full, a pending request is locked until accepted.
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        arb_err
);

  mem_cmd_t inst_cmd;
  mem_cmd_t data_cmd;
  mem_cmd_t sel_cmd;
  logic     sel_id;
  logic     lock_v;
  logic     lock_id;
  logic     fifo_full;
  logic     fifo_empty;
  logic     head_id;
  logic     accept;
  logic     resp_ok;

`ifdef ARB_RR_EN
  logic     last_id;
`endif

  assign inst_cmd = '{wr: inst_wr, size: inst_size, addr: inst_addr, wdata: inst_wdata};
  assign data_cmd = '{wr: data_wr, size: data_size, addr: data_addr, wdata: data_wdata};

  always_comb begin
    sel_id = ARB_ID_INST;
    if (lock_v) begin
      sel_id = lock_id;
    end else if (inst_req && data_req) begin
`ifdef ARB_RR_EN
      sel_id = other_id(last_id);
`else
      sel_id = ARB_ID_DATA;
`endif
    end else if (data_req) begin
      sel_id = ARB_ID_DATA;
    end
  end

  assign sel_cmd   = (sel_id == ARB_ID_DATA) ? data_cmd : inst_cmd;
  assign mem_wr    = sel_cmd.wr;
  assign mem_size  = sel_cmd.size;
  assign mem_addr  = sel_cmd.addr;
  assign mem_wdata = sel_cmd.wdata;

  // Full is taken from registered state only, so a same-cycle pop never reopens the port.
  assign mem_req = (inst_req | data_req) & ~fifo_full & ~reset;
  assign accept  = mem_req & mem_addr_ok;
  assign resp_ok = mem_data_ok & ~fifo_empty & ~reset;

  assign inst_addr_ok = accept & (sel_id == ARB_ID_INST);
  assign data_addr_ok = accept & (sel_id == ARB_ID_DATA);
  assign inst_data_ok = resp_ok & (head_id == ARB_ID_INST);
  assign data_data_ok = resp_ok & (head_id == ARB_ID_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_v  <= 1'b0;
      lock_id <= ARB_ID_INST;
      arb_err <= 1'b0;
    end else begin
      if (mem_req && !mem_addr_ok) begin
        lock_v  <= 1'b1;
        lock_id <= sel_id;
      end else if (mem_addr_ok) begin
        lock_v  <= 1'b0;
      end
      if (mem_data_ok && fifo_empty) arb_err <= 1'b1;
    end
  end

`ifdef ARB_RR_EN
  always_ff @(posedge clk) begin
    if (reset)       last_id <= ARB_ID_INST;
    else if (accept) last_id <= sel_id;
  end
`endif

  arb_tag_fifo #(
    .DEPTH (OUTSTANDING),
    .WIDTH (1)
  ) u_tag_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .pop   (resp_ok),
    .din   (sel_id),
    .dout  (head_id),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a queue-based model of the arbitration and response routing rules.
module tb_mem_req_arbiter;
  import mem_req_arbiter_pkg::*;

  localparam int OUT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;
  logic        arb_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: owners of accepted-but-unanswered requests, oldest first.
  bit q[$];
  bit pinned_v  = 1'b0;
  bit pinned_id = 1'b0;
  bit m_err     = 1'b0;
`ifdef ARB_RR_EN
  bit last_grant = 1'b0;
`endif

  always #5 clk = ~clk;

  mem_req_arbiter #(.OUTSTANDING(OUT)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .arb_err(arb_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Evaluated at the negedge: inputs are stable and equal to what the coming edge samples.
  task automatic model_step();
    bit win, ereq, acc, full, err_set, owner, has_resp;
    if (reset) begin
      chk("rst_mem_req", mem_req, 0);
      chk("rst_inst_addr_ok", inst_addr_ok, 0);
      chk("rst_data_addr_ok", data_addr_ok, 0);
      chk("rst_inst_data_ok", inst_data_ok, 0);
      chk("rst_data_data_ok", data_data_ok, 0);
      chk("rst_arb_err", arb_err, m_err);
      q.delete();
      pinned_v = 1'b0;
      m_err    = 1'b0;
`ifdef ARB_RR_EN
      last_grant = ARB_ID_INST;
`endif
      return;
    end
    full = (q.size() == OUT);
    if (pinned_v) win = pinned_id;
    else if (inst_req && data_req) begin
`ifdef ARB_RR_EN
      win = (last_grant == ARB_ID_INST) ? ARB_ID_DATA : ARB_ID_INST;
`else
      win = ARB_ID_DATA;
`endif
    end else win = data_req ? ARB_ID_DATA : ARB_ID_INST;
    ereq = (inst_req || data_req) && !full;
    chk("mem_req", mem_req, ereq);
    if (ereq) begin
      chk("mem_addr",  mem_addr,  win ? data_addr  : inst_addr);
      chk("mem_wdata", mem_wdata, win ? data_wdata : inst_wdata);
      chk("mem_wr",    mem_wr,    win ? data_wr    : inst_wr);
      chk("mem_size",  mem_size,  win ? data_size  : inst_size);
    end
    acc = ereq && mem_addr_ok;
    chk("inst_addr_ok", inst_addr_ok, acc && win == ARB_ID_INST);
    chk("data_addr_ok", data_addr_ok, acc && win == ARB_ID_DATA);
    has_resp = 1'b0;
    owner    = 1'b0;
    err_set  = 1'b0;
    if (mem_data_ok) begin
      if (q.size() > 0) begin
        has_resp = 1'b1;
        owner    = q.pop_front();
      end else err_set = 1'b1;
    end
    chk("inst_data_ok", inst_data_ok, has_resp && owner == ARB_ID_INST);
    chk("data_data_ok", data_data_ok, has_resp && owner == ARB_ID_DATA);
    chk("inst_rdata", inst_rdata, mem_rdata);
    chk("data_rdata", data_rdata, mem_rdata);
    chk("arb_err", arb_err, m_err);
    if (acc) begin
      q.push_back(win);
`ifdef ARB_RR_EN
      last_grant = win;
`endif
    end
    if (ereq && !mem_addr_ok) begin
      pinned_v  = 1'b1;
      pinned_id = win;
    end else if (mem_addr_ok) pinned_v = 1'b0;
    if (err_set) m_err = 1'b1;
  endtask

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      model_step();
    end
  end

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = '0;
  endtask

  // Called just after a negedge: retire accepted requests and drain all tags, bounded.
  task automatic settle();
    logic ia, da;
    int n = 0;
    while (1) begin
      ia = inst_addr_ok;
      da = data_addr_ok;
      next_cyc();
      if (ia) inst_req = 0;
      if (da) data_req = 0;
      mem_addr_ok = 1;
      mem_data_ok = (q.size() > 0);
      mem_rdata   = $urandom;
      if (!inst_req && !data_req && !mem_data_ok) break;
      at_neg();
      n++;
      if (n > 20) begin
        n_checks++;
        n_fail++;
        $display("FAIL settle_budget: %0d cycles used, limit 20", n);
        break;
      end
    end
    idle();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic ia, da;
    reset = 1; inst_wr = 0; inst_size = SIZE_WORD; inst_addr = '0; inst_wdata = '0;
    data_wr = 0; data_size = SIZE_WORD; data_addr = '0; data_wdata = '0;
    idle();
    next_cyc();
    inst_req = 1;
    at_neg();
    chk("reset_blocks_req", mem_req, 0);
    next_cyc();

    // Inst-only read
    reset = 0; inst_req = 1; inst_addr = 32'hBFC0_0000; mem_addr_ok = 1;
    at_neg();
    chk("t1_inst_addr_ok", inst_addr_ok, 1);
    chk("t1_mem_addr", mem_addr, 32'hBFC0_0000);
    chk("t1_data_addr_ok", data_addr_ok, 0);
    next_cyc(); idle();
    at_neg();
    next_cyc(); mem_data_ok = 1; mem_rdata = 32'h3C08_0001;
    at_neg();
    chk("t1_inst_data_ok", inst_data_ok, 1);
    chk("t1_inst_rdata", inst_rdata, 32'h3C08_0001);
    chk("t1_data_data_ok", data_data_ok, 0);
    next_cyc(); idle();

    // Simultaneous requests
    inst_req = 1; inst_addr = 32'h1000;
    data_req = 1; data_wr = 1; data_addr = 32'h2000; data_wdata = 32'hDEAD_BEEF;
    mem_addr_ok = 1;
    at_neg();
    chk("t2_first_addr", mem_addr, 32'h2000);
    chk("t2_first_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("t2_data_addr_ok", data_addr_ok, 1);
    chk("t2_inst_addr_ok_0", inst_addr_ok, 0);
    next_cyc(); data_req = 0;
    at_neg();
    chk("t2_second_addr", mem_addr, 32'h1000);
    chk("t2_inst_addr_ok", inst_addr_ok, 1);
    next_cyc(); idle(); mem_data_ok = 1; mem_rdata = 32'hAAAA_0001;
    at_neg();
    chk("t2_resp1_data", data_data_ok, 1);
    chk("t2_resp1_inst", inst_data_ok, 0);
    next_cyc(); mem_data_ok = 1; mem_rdata = 32'hAAAA_0002;
    at_neg();
    chk("t2_resp2_inst", inst_data_ok, 1);
    next_cyc(); idle();

    // Back-to-back tie right after a data grant
    inst_req = 1; inst_addr = 32'h1004;
    data_req = 1; data_wr = 0; data_addr = 32'h2004; mem_addr_ok = 1;
    at_neg();
    chk("t2b_first_addr", mem_addr, 32'h2004);
    next_cyc(); data_addr = 32'h2008;
    at_neg();
`ifdef ARB_RR_EN
    chk("t2b_rr_addr", mem_addr, 32'h1004);
    chk("t2b_rr_inst_ok", inst_addr_ok, 1);
`else
    chk("t2b_fixed_addr", mem_addr, 32'h2008);
    chk("t2b_fixed_data_ok", data_addr_ok, 1);
`endif
    settle();

    // Lock holds data request stable while inst rises
    data_req = 1; data_wr = 1; data_addr = 32'h4000; data_wdata = 32'h1111_2222; mem_addr_ok = 0;
    for (int i = 0; i < 3; i++) begin
      at_neg();
      chk("t3_lock_addr", mem_addr, 32'h4000);
      chk("t3_lock_wdata", mem_wdata, 32'h1111_2222);
      chk("t3_lock_inst_ok", inst_addr_ok, 0);
      next_cyc(); inst_req = 1; inst_addr = 32'h5000;
    end
    mem_addr_ok = 1;
    at_neg();
    chk("t3_data_acc", data_addr_ok, 1);
    chk("t3_data_acc_addr", mem_addr, 32'h4000);
    next_cyc(); data_req = 0;
    at_neg();
    chk("t3_inst_acc", inst_addr_ok, 1);
    chk("t3_inst_acc_addr", mem_addr, 32'h5000);
    settle();

    // Full FIFO blocks the third request even with a same-cycle response
    inst_req = 1; inst_addr = 32'h6000; mem_addr_ok = 1;
    at_neg(); chk("t4_acc1", inst_addr_ok, 1);
    next_cyc(); inst_addr = 32'h6004;
    at_neg(); chk("t4_acc2", inst_addr_ok, 1);
    next_cyc(); inst_addr = 32'h6008; mem_data_ok = 1; mem_rdata = 32'h55;
    at_neg();
    chk("t4_full_mem_req", mem_req, 0);
    chk("t4_full_no_acc", inst_addr_ok, 0);
    chk("t4_full_resp", inst_data_ok, 1);
    next_cyc(); mem_data_ok = 0;
    at_neg();
    chk("t4_resume_req", mem_req, 1);
    chk("t4_resume_acc", inst_addr_ok, 1);
    settle();

    // Response with no outstanding tag
    mem_data_ok = 1; mem_rdata = 32'h77;
    at_neg();
    chk("t5_no_inst_ok", inst_data_ok, 0);
    chk("t5_no_data_ok", data_data_ok, 0);
    next_cyc(); mem_data_ok = 0;
    at_neg(); chk("t5_err_set", arb_err, 1);
    next_cyc(); next_cyc();
    at_neg(); chk("t5_err_sticky", arb_err, 1);
    next_cyc();

    // Reset with two tags outstanding
    inst_req = 1; inst_addr = 32'h7000; mem_addr_ok = 1;
    at_neg(); chk("t6_acc1", inst_addr_ok, 1);
    next_cyc(); inst_addr = 32'h7004;
    at_neg(); chk("t6_acc2", inst_addr_ok, 1);
    next_cyc(); inst_req = 0; mem_addr_ok = 0; reset = 1;
    at_neg(); chk("t6_reset_mem_req", mem_req, 0);
    next_cyc(); reset = 0;
    at_neg();
    chk("t6_err_cleared", arb_err, 0);
    chk("t6_idle_mem_req", mem_req, 0);
    next_cyc(); inst_req = 1; inst_addr = 32'h7100; mem_addr_ok = 1;
    at_neg(); chk("t6_post_acc1", inst_addr_ok, 1);
    next_cyc(); inst_addr = 32'h7104;
    at_neg(); chk("t6_post_acc2", inst_addr_ok, 1);
    settle();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      at_neg();
      ia = inst_addr_ok;
      da = data_addr_ok;
      next_cyc();
      reset = ($urandom_range(0, 299) == 0);
      if (!inst_req || ia) begin
        inst_req   = ($urandom_range(0, 2) != 0);
        inst_wr    = 0;
        inst_size  = SIZE_WORD;
        inst_addr  = $urandom & 32'hFFFF_FFFC;
        inst_wdata = $urandom;
      end
      if (!data_req || da) begin
        data_req   = ($urandom_range(0, 2) != 0);
        data_wr    = $urandom_range(0, 1) != 0;
        case ($urandom_range(0, 2))
          0:       data_size = SIZE_BYTE;
          1:       data_size = SIZE_HALF;
          default: data_size = SIZE_WORD;
        endcase
        data_addr  = $urandom;
        data_wdata = $urandom;
      end
      mem_addr_ok = ($urandom_range(0, 3) != 0);
      mem_data_ok = (q.size() > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 99) == 0);
      mem_rdata   = $urandom;
    end
    at_neg();
    next_cyc();
    idle();
    reset = 0;
    at_neg();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
